priority_irq_controller: RTL

PRIORITY_IRQ_CONTROLLER -- requirements
Module: priority_irq_controller

---
 rtl/priority_irq_controller.sv | 110 +++++++++++
 1 files changed

// File: rtl/priority_irq_controller.sv
// Edge-triggered 8-line priority interrupt controller with valid/ready offer and EOI.
// Optional per-line eligibility mask is enabled by defining IRQ_MASK_EN.
module priority_irq_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
`ifdef IRQ_MASK_EN
  input  logic [7:0] irq_mask,
`endif
  input  logic       irq_ready,
  input  logic       irq_eoi,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] irq_pend,
  output logic       irq_lost
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_prev;
  logic [7:0] r_pend;
  logic [2:0] r_id;
  logic       r_valid;
  logic       r_lost;

  logic [7:0] w_rise;
  logic [7:0] w_elig;
  logic       w_hs;
  logic [7:0] w_clr;
  logic [7:0] w_pend_nxt;
  logic       w_lost_nxt;

  // Highest set bit wins; bit 7 is the top priority.
  function automatic logic [2:0] f_highest(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = i[2:0];
    end
    return idx;
  endfunction

  // Edge detect, eligibility and next pending state.
  always_comb begin
    w_rise = irq_in & ~r_prev;
`ifdef IRQ_MASK_EN
    w_elig = r_pend & irq_mask;
`else
    w_elig = r_pend;
`endif
    w_hs = (r_state == S_OFFER) && r_valid && irq_ready;
    if (w_hs) begin
      w_clr = 8'b0000_0001 << r_id;
    end else begin
      w_clr = 8'h00;
    end
    // A new edge on the line being acknowledged re-arms it instead of counting as lost.
    w_pend_nxt = (r_pend & ~w_clr) | w_rise;
    w_lost_nxt = |(w_rise & r_pend & ~w_clr);
  end

  // Pending register, lost pulse and offer/busy FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_prev  <= 8'h00;
      r_pend  <= 8'h00;
      r_id    <= 3'd0;
      r_valid <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_prev <= irq_in;
      r_pend <= w_pend_nxt;
      r_lost <= w_lost_nxt;
      case (r_state)
        S_IDLE: begin
          if (|w_elig) begin
            r_id    <= f_highest(w_elig);
            r_valid <= 1'b1;
            r_state <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (irq_eoi) r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign irq_valid = r_valid;
  assign irq_id    = r_id;
  assign irq_pend  = r_pend;
  assign irq_lost  = r_lost;

endmodule
